uart_tx_frame: RTL and testbench

Parametrised UART transmitter with an internal baud-rate divider and a valid/ready byte interface. Frame format is fixed at elaboration: data width, parity mode and stop-bit count are parameters. It replaces the fixed 8N1 FSM transmitter and its external `tx_en` tick. It sits between a FIFO (or any valid/ready source) and the board's serial TX pin.

---
 rtl/uart_tx_frame.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter with a built-in baud divider and a valid/ready byte input.
// Data width, parity mode and stop-bit count are fixed at elaboration.
module uart_tx_frame #(
  parameter int BAUD_DIV  = 10416,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 TxD
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_frame: BAUD_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Odd mode inverts the XOR so the total count of ones including parity is odd.
  function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
    logic p;
    p = ^d;
    if (PARITY == 1) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

  state_t                 state_r, state_s;
  logic [BW-1:0]          baud_cnt_r, baud_cnt_s;
  logic [CW-1:0]          bit_cnt_r, bit_cnt_s;
  logic [DATA_BITS-1:0]   shift_r, shift_s;
  logic                   parity_r, parity_s;
  logic                   txd_r, txd_s;
  logic                   ready_r, busy_r;
  logic                   done_r, done_s;
  logic                   bit_end_s;

  assign bit_end_s = (baud_cnt_r == BAUD_LAST);

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    parity_s   = parity_r;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        baud_cnt_s = '0;
        bit_cnt_s  = '0;
        if (tx_valid) begin
          state_s  = ST_START;
          shift_s  = tx_data;
          parity_s = parity_f(tx_data);
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_cnt_s = '0;
          bit_cnt_s  = '0;
          state_s    = ST_DATA;
        end else begin
          baud_cnt_s = baud_cnt_r + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_cnt_s = '0;
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_s = '0;
            state_s   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + 1'b1;
            shift_s   = {1'b0, shift_r[DATA_BITS-1:1]};
          end
        end else begin
          baud_cnt_s = baud_cnt_r + 1'b1;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          baud_cnt_s = '0;
          bit_cnt_s  = '0;
          state_s    = ST_STOP;
        end else begin
          baud_cnt_s = baud_cnt_r + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          baud_cnt_s = '0;
          if (bit_cnt_r == STOP_LAST) begin
            bit_cnt_s = '0;
            state_s   = ST_IDLE;
            done_s    = 1'b1;
          end else begin
            bit_cnt_s = bit_cnt_r + 1'b1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + 1'b1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        baud_cnt_s = '0;
        bit_cnt_s  = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so TxD can be a plain flop.
  always_comb begin
    txd_s = 1'b1;
    case (state_s)
      ST_IDLE:   txd_s = 1'b1;
      ST_START:  txd_s = 1'b0;
      ST_DATA:   txd_s = shift_s[0];
      ST_PARITY: txd_s = parity_s;
      ST_STOP:   txd_s = 1'b1;
      default:   txd_s = 1'b1;
    endcase
  end

  // State and output registers; reset wins over a simultaneous accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      parity_r   <= 1'b0;
      txd_r      <= 1'b1;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      parity_r   <= parity_s;
      txd_r      <= txd_s;
      ready_r    <= (state_s == ST_IDLE);
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= done_s;
    end
  end

  assign tx_ready = ready_r;
  assign tx_busy  = busy_r;
  assign tx_done  = done_r;
  assign TxD      = txd_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four frame configurations share one clock/reset,
// expected line bits are queued at accept and compared cycle by cycle.
module tb_uart_tx_frame;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tdata;
  logic [3:0] valid_v, ready_v, busy_v, done_v, txd_v;

  int db  [4] = '{8, 8, 8, 7};
  int par [4] = '{0, 2, 1, 0};
  int sb  [4] = '{1, 1, 1, 2};

  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
    .tx_data(tdata), .tx_busy(busy_v[0]), .tx_done(done_v[0]), .TxD(txd_v[0]));

  uart_tx_frame #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
    .tx_data(tdata), .tx_busy(busy_v[1]), .tx_done(done_v[1]), .TxD(txd_v[1]));

  uart_tx_frame #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
    .tx_data(tdata), .tx_busy(busy_v[2]), .tx_done(done_v[2]), .TxD(txd_v[2]));

  uart_tx_frame #(.BAUD_DIV(B), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset(reset), .tx_valid(valid_v[3]), .tx_ready(ready_v[3]),
    .tx_data(tdata[6:0]), .tx_busy(busy_v[3]), .tx_done(done_v[3]), .TxD(txd_v[3]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits.
  task automatic push_frame(input int sel, input logic [7:0] d);
    logic x;
    x = 1'b0;
    exp_q.push_back(1'b0);
    for (int j = 0; j < db[sel]; j++) begin
      exp_q.push_back(d[j]);
      x = x ^ d[j];
    end
    if (par[sel] != 0) exp_q.push_back((par[sel] == 1) ? ~x : x);
    for (int s = 0; s < sb[sel]; s++) exp_q.push_back(1'b1);
  endtask

  task automatic accept(input int sel, input logic [7:0] d);
    tdata        = d;
    valid_v[sel] = 1'b1;
    check_eq("ready_before_accept", ready_v[sel], 1);
    tick();
    check_eq("ready_after_accept", ready_v[sel], 0);
    check_eq("busy_after_accept", busy_v[sel], 1);
    check_eq("start_bit_now", txd_v[sel], 0);
    push_frame(sel, d);
  endtask

  task automatic watch(input int sel);
    logic b;
    int   n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      b = exp_q.pop_front();
      for (int c = 0; c < B; c++) begin
        check_eq($sformatf("txd_bit%0d_c%0d", i, c), txd_v[sel], b);
        check_eq("done_early", done_v[sel], 0);
        tick();
      end
    end
    check_eq("done_at_end", done_v[sel], 1);
    check_eq("ready_at_end", ready_v[sel], 1);
    check_eq("busy_at_end", busy_v[sel], 0);
    check_eq("txd_mark_at_end", txd_v[sel], 1);
  endtask

  initial begin
    valid_v = 4'b0000;
    tdata   = 8'h00;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    for (int s = 0; s < 4; s++) begin
      check_eq("rst_txd", txd_v[s], 1);
      check_eq("rst_ready", ready_v[s], 1);
      check_eq("rst_busy", busy_v[s], 0);
      check_eq("rst_done", done_v[s], 0);
    end

    // Idle with no valid: line stays at mark.
    for (int c = 0; c < 6; c++) begin
      tick();
      check_eq("idle_txd", txd_v[0], 1);
      check_eq("idle_ready", ready_v[0], 1);
    end

    // 8N1 0x55
    accept(0, 8'h55);
    valid_v[0] = 1'b0;
    watch(0);
    tick();
    check_eq("done_one_cycle", done_v[0], 0);

    // Data changed after accept has no effect
    accept(0, 8'h12);
    valid_v[0] = 1'b0;
    tdata = 8'hFF;
    watch(0);
    tick();

    // Back-to-back with valid held high
    accept(0, 8'hA5);
    tdata = 8'h3C;
    watch(0);
    tick();
    check_eq("b2b_second_accept", ready_v[0], 0);
    check_eq("b2b_start_bit", txd_v[0], 0);
    push_frame(0, 8'h3C);
    valid_v[0] = 1'b0;
    watch(0);
    tick();

    // Parity: even 0x07, odd 0x07, odd 0x00
    accept(1, 8'h07);
    valid_v[1] = 1'b0;
    watch(1);
    tick();
    accept(2, 8'h07);
    valid_v[2] = 1'b0;
    watch(2);
    tick();
    accept(2, 8'h00);
    valid_v[2] = 1'b0;
    watch(2);
    tick();

    // 7 data bits, 2 stop bits
    accept(3, 8'h41);
    valid_v[3] = 1'b0;
    watch(3);
    tick();

    // Reset during data bit 3
    accept(0, 8'hC3);
    valid_v[0] = 1'b0;
    repeat (17) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_txd", txd_v[0], 1);
    check_eq("midrst_ready", ready_v[0], 1);
    check_eq("midrst_busy", busy_v[0], 0);
    check_eq("midrst_done", done_v[0], 0);
    exp_q.delete();
    for (int c = 0; c < 3 * B; c++) begin
      tick();
      check_eq("postrst_no_done", done_v[0], 0);
      check_eq("postrst_txd", txd_v[0], 1);
    end
    accept(0, 8'h81);
    valid_v[0] = 1'b0;
    watch(0);
    tick();

    // Reset wins over a simultaneous accept
    tdata      = 8'h99;
    valid_v[0] = 1'b1;
    reset      = 1'b1;
    tick();
    reset      = 1'b0;
    valid_v[0] = 1'b0;
    check_eq("rst_prio_ready", ready_v[0], 1);
    check_eq("rst_prio_txd", txd_v[0], 1);
    tick();
    check_eq("rst_prio_still_idle", ready_v[0], 1);
    check_eq("rst_prio_no_start", txd_v[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
